// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: UART loopback with RX, a circular FIFO and TX.
// Ports: clk, rst (sync, active-high), rx (async serial in), cts_n
// (0 = TX may start frames), tx (serial out), fifo_level (occupied
// entries), overflow (sticky drop flag), frame_err / parity_err (pulses).
// Optional even parity on both directions: define UART_ECHO_PARITY_EN.
module uart_echo_fifo #(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE    = 9600,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          cts_n,
    output logic                          tx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err,
    output logic                          parity_err
);

    localparam int CPB  = SYSTEM_CLOCK / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);

    // rx synchronizer plus one more stage for falling-edge detection
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_ECHO_PARITY_EN
        RX_PAR,
`endif
        RX_STOP
    } rx_state_t;

    rx_state_t            rx_state, rx_state_n;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [BW-1:0]        rx_bitn, rx_bitn_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic                 push;
    logic                 ferr_n;
    logic                 perr_n;
    logic                 rx_pbad;
`ifdef UART_ECHO_PARITY_EN
    logic                 rx_par, rx_par_n, rx_pbad_q, rx_pbad_n;
    assign rx_pbad = rx_pbad_q;
`else
    assign rx_pbad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bitn   <= '0;
            rx_shift  <= '0;
            frame_err <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
            rx_par    <= 1'b0;
            rx_pbad_q <= 1'b0;
`endif
        end else begin
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_bitn   <= rx_bitn_n;
            rx_shift  <= rx_shift_n;
            frame_err <= ferr_n;
`ifdef UART_ECHO_PARITY_EN
            rx_par    <= rx_par_n;
            rx_pbad_q <= rx_pbad_n;
`endif
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CW'(1);
        rx_bitn_n  = rx_bitn;
        rx_shift_n = rx_shift;
        push       = 1'b0;
        ferr_n     = 1'b0;
        perr_n     = 1'b0;
`ifdef UART_ECHO_PARITY_EN
        rx_par_n   = rx_par;
        rx_pbad_n  = rx_pbad_q;
`endif
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_sync)
                    rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == CW'(HALF - 1)) begin
                    rx_cnt_n  = '0;
                    rx_bitn_n = '0;
`ifdef UART_ECHO_PARITY_EN
                    rx_par_n  = 1'b0;
                    rx_pbad_n = 1'b0;
`endif
                    // still low at mid-bit: real start, else a glitch
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == CW'(CPB - 1)) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
                    rx_bitn_n  = rx_bitn + BW'(1);
`ifdef UART_ECHO_PARITY_EN
                    rx_par_n   = rx_par ^ rx_sync;
                    if (rx_bitn == BW'(DATA_BITS - 1))
                        rx_state_n = RX_PAR;
`else
                    if (rx_bitn == BW'(DATA_BITS - 1))
                        rx_state_n = RX_STOP;
`endif
                end
            end
`ifdef UART_ECHO_PARITY_EN
            RX_PAR: begin
                if (rx_cnt == CW'(CPB - 1)) begin
                    rx_cnt_n   = '0;
                    rx_pbad_n  = rx_par ^ rx_sync;
                    rx_state_n = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt == CW'(CPB - 1)) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    ferr_n     = !rx_sync;
                    perr_n     = rx_pbad;
                    push       = rx_sync && !rx_pbad;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

`ifdef UART_ECHO_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= perr_n;
    end
`else
    assign parity_err = 1'b0;
    logic unused_perr;
    assign unused_perr = perr_n;
`endif

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 pop, full, wr_en;

    assign head  = mem[rd_ptr];
    assign full  = (fifo_level == (PW + 1)'(FIFO_DEPTH));
    // a pop in the same cycle frees the slot the push needs
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !pop)
                fifo_level <= fifo_level + (PW + 1)'(1);
            else if (pop && !wr_en)
                fifo_level <= fifo_level - (PW + 1)'(1);
            if (push && !wr_en) overflow <= 1'b1;
        end
    end

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_ECHO_PARITY_EN
        TX_PAR,
`endif
        TX_STOP
    } tx_state_t;

    tx_state_t            tx_state, tx_state_n;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [BW-1:0]        tx_bitn, tx_bitn_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_bit;
`ifdef UART_ECHO_PARITY_EN
    logic                 tx_par, tx_par_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bitn  <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
`ifdef UART_ECHO_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bitn  <= tx_bitn_n;
            tx_shift <= tx_shift_n;
            // line is registered from the current state: one cycle lag
            tx       <= tx_bit;
`ifdef UART_ECHO_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CW'(1);
        tx_bitn_n  = tx_bitn;
        tx_shift_n = tx_shift;
        tx_bit     = 1'b1;
        pop        = 1'b0;
`ifdef UART_ECHO_PARITY_EN
        tx_par_n   = tx_par;
`endif
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (fifo_level != '0 && !cts_n) begin
                    pop        = 1'b1;
                    tx_shift_n = head;
                    tx_bitn_n  = '0;
                    tx_state_n = TX_START;
`ifdef UART_ECHO_PARITY_EN
                    tx_par_n   = ^head;
`endif
                end
            end
            TX_START: begin
                tx_bit = 1'b0;
                if (tx_cnt == CW'(CPB - 1)) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_bit = tx_shift[0];
                if (tx_cnt == CW'(CPB - 1)) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[DATA_BITS-1:1]};
                    tx_bitn_n  = tx_bitn + BW'(1);
`ifdef UART_ECHO_PARITY_EN
                    if (tx_bitn == BW'(DATA_BITS - 1))
                        tx_state_n = TX_PAR;
`else
                    if (tx_bitn == BW'(DATA_BITS - 1))
                        tx_state_n = TX_STOP;
`endif
                end
            end
`ifdef UART_ECHO_PARITY_EN
            TX_PAR: begin
                tx_bit = tx_par;
                if (tx_cnt == CW'(CPB - 1)) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                tx_bit = 1'b1;
                if (tx_cnt == CW'(CPB - 1)) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

endmodule
